// File: rtl/seg_disp_drv_pkg.sv
// Shared definitions for the 7-segment display driver.
// Contents:
//   - value/BCD widths
//   - active-low glyph constants for {dp,g,f,e,d,c,b,a}
//   - the conversion FSM state type
//   - glyph lookup and double-dabble nibble-adjust helpers
package seg_disp_drv_pkg;

    localparam int VAL_W  = 20;        // binary value width
    localparam int FLAG_W = 3;         // parameter index width
    localparam int NIB    = 7;         // BCD working width in nibbles
    localparam int BCD_W  = 4 * NIB;   // BCD working width in bits

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // Decimal digit to glyph; codes above 9 are never produced and show blank.
    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NIB; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset, aborts a running conversion
//   start  in   load din and begin converting (honoured only when idle)
//   din    in   20-bit unsigned value
//   busy   out  high from the cycle after start until the commit cycle ends
//   done   out  one-cycle strobe during COMMIT; bcd is valid while it is high
//   bcd    out  7-nibble BCD result
module bin2bcd_seq
    import seg_disp_drv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    conv_state_t      state, state_next;
    logic [4:0]       cnt;
    logic [VAL_W-1:0] bin;
    logic [BCD_W-1:0] work;
    logic [BCD_W-1:0] work_adj;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SHIFT;
            ST_SHIFT:  if (cnt == 5'd19) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            cnt <= '0;
        end else if (state == ST_SHIFT) begin
            cnt <= cnt + 5'd1;
        end
    end

    assign work_adj = dabble_adjust(work);

    // Shift datapath: MSB of the operand enters the BCD word each SHIFT cycle.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            bin  <= din;
            work <= '0;
        end else if (state == ST_SHIFT) begin
            bin  <= {bin[VAL_W-2:0], 1'b0};
            work <= {work_adj[BCD_W-2:0], bin[VAL_W-1]};
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_COMMIT);
    assign bcd  = work;

endmodule

// File: rtl/seg_disp_drv.sv
// 8-digit multiplexed 7-segment display driver.
// Shows the parameter index on the leftmost digit, a dash, then the value in
// decimal with leading-zero blanking (all dashes when above 999_999).
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   disp_data  in   20-bit unsigned value to display
//   flag       in   3-bit parameter index
//   sel        out  digit select, one-hot active-low, bit0 = rightmost digit
//   seg        out  segments {dp,g,f,e,d,c,b,a}, active-low
//   busy       out  high while a BCD conversion is in progress
module seg_disp_drv
    import seg_disp_drv_pkg::*;
#(
    parameter int SCAN_DIV = 50_000,
    parameter int NUM_DIG  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [VAL_W-1:0]  disp_data,
    input  logic [FLAG_W-1:0] flag,
    output logic [7:0]        sel,
    output logic [7:0]        seg,
    output logic              busy
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [VAL_W-1:0]  snap_val;
    logic [FLAG_W-1:0] snap_flag;
    logic              start;
    logic              conv_busy;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    logic [BCD_W-1:0]  disp_bcd;
    logic [FLAG_W-1:0] disp_flag;
    logic [PW-1:0]     presc;
    logic [2:0]        idx;
    logic [3:0]        nib [8];
    logic [2:0]        msd;
    logic              overflow;
    logic [7:0]        digit_glyph;

    // A new conversion is only launched from idle, so an input change while
    // busy is picked up once the current result has been committed.
    assign start = !conv_busy && ({disp_data, flag} != {snap_val, snap_flag});

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_val  <= '0;
            snap_flag <= '0;
        end else if (start) begin
            snap_val  <= disp_data;
            snap_flag <= flag;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (disp_data),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign busy = conv_busy;

    // Digits and index are replaced together so the display never mixes
    // an old index with a new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_bcd  <= '0;
            disp_flag <= '0;
        end else if (conv_done) begin
            disp_bcd  <= conv_bcd;
            disp_flag <= snap_flag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == 3'(NUM_DIG - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) nib[i] = '0;
        for (int i = 0; i < NIB; i++) nib[i] = disp_bcd[4*i +: 4];
    end

    // Position of the most significant nonzero value digit; 0 when the value
    // is zero so that a single '0' is shown.
    always_comb begin
        msd = '0;
        for (int i = 0; i < 6; i++) begin
            if (nib[i] != 4'd0) msd = 3'(i);
        end
    end

    assign overflow = (nib[6] != 4'd0);

    always_comb begin
        digit_glyph = SEG_BLANK;
        case (idx)
            3'd7:    digit_glyph = glyph({1'b0, disp_flag});
            3'd6:    digit_glyph = SEG_DASH;
            default: begin
                if (overflow)        digit_glyph = SEG_DASH;
                else if (idx <= msd) digit_glyph = glyph(nib[idx]);
                else                 digit_glyph = SEG_BLANK;
            end
        endcase
    end

    // sel and seg are registered from the same index so they switch together.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            sel <= ~(8'h01 << idx);
            seg <= digit_glyph;
        end
    end

endmodule

// File: tb/tb_seg_disp_drv.sv
module tb_seg_disp_drv;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] disp_data;
    logic [2:0]  flag;
    logic [7:0]  sel;
    logic [7:0]  seg;
    logic        busy;

    int errors = 0;
    int checks = 0;

    seg_disp_drv #(.SCAN_DIV(SCAN_DIV), .NUM_DIG(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .disp_data (disp_data),
        .flag      (flag),
        .sel       (sel),
        .seg       (seg),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_glyph(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected glyph at a digit position for a displayed (value, index) pair.
    function automatic logic [7:0] ref_digit(input int pos, input int val, input int flg);
        int p;
        if (pos == 7) return ref_glyph(flg);
        if (pos == 6) return 8'hBF;
        if (val > 999_999) return 8'hBF;
        p = 1;
        for (int k = 0; k < pos; k++) p = p * 10;
        if (pos > 0 && val < p) return 8'hFF;
        return ref_glyph((val / p) % 10);
    endfunction

    function automatic int sel_pos(input logic [7:0] s);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m = ~(8'h01 << i);
            if (s === m) return i;
        end
        return -1;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the currently lit digit against the model.
    task automatic cur_check(input string tag, input int val, input int flg);
        int p;
        p = sel_pos(sel);
        chk({tag, "_sel_onehot"}, 32'(p >= 0), 32'd1);
        if (p >= 0) chk(tag, 32'(seg), 32'(ref_digit(p, val, flg)));
    endtask

    // Observe one full scan and check every digit once.
    task automatic disp_check(input string tag, input int val, input int flg);
        logic [7:0] seen;
        int p;
        seen = '0;
        repeat (8 * SCAN_DIV + 2) begin
            @(negedge clk);
            p = sel_pos(sel);
            if (p >= 0 && !seen[p]) begin
                seen[p] = 1'b1;
                chk($sformatf("%s_d%0d", tag, p), 32'(seg), 32'(ref_digit(p, val, flg)));
            end
        end
        chk({tag, "_all_digits"}, 32'(seen), 32'hFF);
    endtask

    task automatic apply(input int val, input int flg);
        @(posedge clk);
        #1;
        disp_data = 20'(val);
        flag      = 3'(flg);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(posedge clk);
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int busy_cnt, fall1, fall2, run, first_change, rose, v, nd, flg;
        logic [7:0] prev;
        logic prev_busy;

        // 1. reset state and idle with zero inputs
        reset = 1'b1; disp_data = '0; flag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", 32'(sel), 32'hFF);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        rose = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) rose = 1;
        end
        chk("idle_busy_never", 32'(rose), 32'd0);
        disp_check("zero", 0, 0);

        // 5. scan order and per-digit hold time
        @(negedge clk);
        prev = sel; run = 1; first_change = 0;
        repeat (8 * SCAN_DIV * 2 + 4) begin
            @(negedge clk);
            cur_check("scan_seg", 0, 0);
            if (sel === prev) begin
                run++;
            end else begin
                chk("scan_order", 32'(sel), 32'({prev[6:0], prev[7]}));
                if (first_change) chk("scan_hold", 32'(run), SCAN_DIV);
                first_change = 1;
                run = 1;
                prev = sel;
            end
        end

        // 2. 800 / index 3: busy width and commit latency
        apply(800, 3);
        busy_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_cnt++;
            if (n == 21) cur_check("lat_old", 0, 0);
            if (n == 22) cur_check("lat_new", 800, 3);
        end
        chk("busy_width", busy_cnt, 21);
        disp_check("v800", 800, 3);

        // 3. overflow
        apply(20'hFFFFF, 2);
        wait_idle("ovf");
        disp_check("ovf", 20'hFFFFF, 2);

        // 4. input change during conversion
        apply(123, 1);
        fall1 = -1; fall2 = -1; prev_busy = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            if (n == 4) begin #1 disp_data = 20'd456; end
            @(negedge clk);
            if (prev_busy && !busy) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            prev_busy = busy;
            if (n == 22) cur_check("chg_first", 123, 1);
            if (n == 43) cur_check("chg_still_first", 123, 1);
            if (n == 44) cur_check("chg_second", 456, 1);
        end
        chk("chg_fall1", fall1, 21);
        chk("chg_gap", fall2 - fall1, 22);
        disp_check("v456", 456, 1);

        // 6. reset in the middle of a conversion
        apply(999_999, 4);
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sel", 32'(sel), 32'hFF);
        chk("abort_seg", 32'(seg), 32'hFF);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reconv_busy", 32'(busy), 32'd1);
        chk("reconv_sel", 32'(sel), 32'hFE);
        chk("reconv_seg_zero", 32'(seg), 32'hC0);
        wait_idle("reconv");
        disp_check("v999999", 999_999, 4);

        // randomized values of varying magnitude
        for (int k = 0; k < 8; k++) begin
            nd = $urandom_range(1, 7);
            if (nd == 7) v = int'($urandom % 1048576);
            else begin
                v = 1;
                for (int j = 0; j < nd; j++) v = v * 10;
                v = int'($urandom % v);
            end
            flg = $urandom_range(0, 7);
            apply(v, flg);
            wait_idle($sformatf("rnd%0d", k));
            disp_check($sformatf("rnd%0d", k), v, flg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
